// File: rtl/addsub_arbiter_pkg.sv
// Shared constants and types for the two-port add/sub arbiter.
// Holds the default datapath width and the requester id type.
package addsub_arbiter_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

  function automatic port_id_t other_port(input port_id_t p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/addsub_unit.sv
// WIDTH-bit ripple adder/subtractor; subtraction is a + ~b + 1.
// cout reports carry for add and borrow (a < b unsigned) for subtract.
module addsub_unit
  import addsub_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   carry;

  assign b_eff    = b ^ {WIDTH{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign s[i]         = a[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
  end

  // A subtract with no carry out of the top bit means a borrow occurred.
  assign cout = sub ^ carry[WIDTH];

endmodule

// File: rtl/addsub_arbiter.sv
// Two requesters share one add/sub unit; round-robin on ties, one grant per cycle.
// Each port has a single response register with valid/ready handshake.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_s,
  output logic             rsp0_cout,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_s,
  output logic             rsp1_cout
);

  port_id_t         last_q;
  port_id_t         last_d;
  logic             elig0;
  logic             elig1;
  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic [WIDTH-1:0] res_s;
  logic             res_cout;

  // A port may take a new result when its register is empty or draining now.
  assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

  // Pointer register: remembers the most recently granted port.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PORT1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant0) begin
      last_d = PORT0;
    end else if (grant1) begin
      last_d = PORT1;
    end
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        grant0 = (other_port(last_q) == PORT0);
        grant1 = (other_port(last_q) == PORT1);
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    op_a   = req0_a;
    op_b   = req0_b;
    op_sub = req0_sub;
    if (grant1) begin
      op_a   = req1_a;
      op_b   = req1_b;
      op_sub = req1_sub;
    end
  end

  addsub_unit #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a    (op_a),
    .b    (op_b),
    .sub  (op_sub),
    .s    (res_s),
    .cout (res_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_s     <= '0;
      rsp0_cout  <= 1'b0;
    end else if (grant0) begin
      rsp0_valid <= 1'b1;
      rsp0_s     <= res_s;
      rsp0_cout  <= res_cout;
    end else if (rsp0_valid && rsp0_ready) begin
      rsp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp1_valid <= 1'b0;
      rsp1_s     <= '0;
      rsp1_cout  <= 1'b0;
    end else if (grant1) begin
      rsp1_valid <= 1'b1;
      rsp1_s     <= res_s;
      rsp1_cout  <= res_cout;
    end else if (rsp1_valid && rsp1_ready) begin
      rsp1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: directed scenarios then randomized traffic.
// A negedge monitor models arbitration and results from plain arithmetic.
module tb_addsub_arbiter;

  typedef struct {
    logic [15:0] s;
    logic        c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [15:0] rsp0_s, rsp1_s;
  logic        rsp0_cout, rsp1_cout;

  int vectors = 0;
  int miscompares = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   m_last = 1;

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_s(rsp0_s), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_s(rsp1_s), .rsp1_cout(rsp1_cout)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %04h expected %04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
    int unsigned ua;
    int unsigned ub;
    int unsigned r;
    exp_t e;
    ua = {16'h0, a};
    ub = {16'h0, b};
    if (sub) begin
      r   = ua - ub;
      e.c = (ua < ub);
    end else begin
      r   = ua + ub;
      e.c = (r > 32'h0000_FFFF);
    end
    e.s = r[15:0];
    return e;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: arbitration rule, latency-1 delivery and hold-while-stalled, all per port.
  always @(negedge clk) begin
    logic e0, e1, g0, g1;
    if (rst) begin
      chk1("rst_req0_ready", req0_ready, 1'b0);
      chk1("rst_req1_ready", req1_ready, 1'b0);
      q0.delete();
      q1.delete();
      m_last = 1;
    end else begin
      e0 = req0_valid && (q0.size() == 0 || rsp0_ready);
      e1 = req1_valid && (q1.size() == 0 || rsp1_ready);
      if (e0 && e1) begin
        g0 = (m_last == 1);
        g1 = (m_last == 0);
      end else begin
        g0 = e0;
        g1 = e1;
      end
      chk1("grant0", req0_ready, g0);
      chk1("grant1", req1_ready, g1);
      if (g0) m_last = 0;
      else if (g1) m_last = 1;

      chk1("rsp0_valid", rsp0_valid, q0.size() != 0);
      if (q0.size() != 0) begin
        chk16("rsp0_s", rsp0_s, q0[0].s);
        chk1("rsp0_cout", rsp0_cout, q0[0].c);
        if (rsp0_ready) void'(q0.pop_front());
      end
      chk1("rsp1_valid", rsp1_valid, q1.size() != 0);
      if (q1.size() != 0) begin
        chk16("rsp1_s", rsp1_s, q1[0].s);
        chk1("rsp1_cout", rsp1_cout, q1[0].c);
        if (rsp1_ready) void'(q1.pop_front());
      end

      if (g0) q0.push_back(ref_op(req0_a, req0_b, req0_sub));
      if (g1) q1.push_back(ref_op(req1_a, req1_b, req1_sub));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, n1;
    logic acc0, acc1;

    // Reset with both requesters already presenting the first tie.
    req0_a = 16'h0005; req0_b = 16'h0003; req0_sub = 1'b0; req0_valid = 1'b1;
    req1_a = 16'h0003; req1_b = 16'h0005; req1_sub = 1'b1; req1_valid = 1'b1;
    rst = 1'b1;
    step();
    @(negedge clk);
    chk1("reset_rsp0_valid", rsp0_valid, 1'b0);
    chk1("reset_rsp1_valid", rsp1_valid, 1'b0);
    chk16("reset_rsp0_s", rsp0_s, 16'h0000);
    chk16("reset_rsp1_s", rsp1_s, 16'h0000);
    chk1("reset_rsp0_cout", rsp0_cout, 1'b0);
    step();
    rst = 1'b0;

    @(negedge clk);
    chk1("tie_first_req0_ready", req0_ready, 1'b1);
    chk1("tie_first_req1_ready", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk1("add5p3_valid", rsp0_valid, 1'b1);
    chk16("add5p3_s", rsp0_s, 16'h0008);
    chk1("add5p3_cout", rsp0_cout, 1'b0);
    chk1("tie_second_req1_ready", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    chk16("sub3m5_s", rsp1_s, 16'hFFFE);
    chk1("sub3m5_cout", rsp1_cout, 1'b1);
    step();

    // Wrap on add, equal-operand subtract.
    req0_a = 16'hFFFF; req0_b = 16'h0001; req0_sub = 1'b0; req0_valid = 1'b1;
    @(negedge clk);
    chk1("wrap_req0_ready", req0_ready, 1'b1);
    step();
    req0_a = 16'h8000; req0_b = 16'h8000; req0_sub = 1'b1;
    @(negedge clk);
    chk16("wrap_add_s", rsp0_s, 16'h0000);
    chk1("wrap_add_cout", rsp0_cout, 1'b1);
    chk1("wrap_req0_ready2", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk16("eq_sub_s", rsp0_s, 16'h0000);
    chk1("eq_sub_cout", rsp0_cout, 1'b0);
    step();

    // Backpressure on port 1 for five cycles.
    rsp1_ready = 1'b0;
    req1_a = 16'h1234; req1_b = 16'h0034; req1_sub = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk1("bp_first_grant", req1_ready, 1'b1);
    step();
    req1_a = 16'h0001; req1_b = 16'h0002; req1_sub = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("bp_req1_ready", req1_ready, 1'b0);
      chk1("bp_rsp1_valid", rsp1_valid, 1'b1);
      chk16("bp_rsp1_s", rsp1_s, 16'h1200);
      chk1("bp_rsp1_cout", rsp1_cout, 1'b0);
      step();
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk1("bp_release_ready", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    chk16("bp_new_s", rsp1_s, 16'hFFFF);
    chk1("bp_new_cout", rsp1_cout, 1'b1);

    // Both ports saturated: strict alternation starting at port 0.
    step();
    req0_a = rnd16(); req0_b = rnd16(); req0_sub = 1'($urandom); req0_valid = 1'b1;
    req1_a = rnd16(); req1_b = rnd16(); req1_sub = 1'($urandom); req1_valid = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc0 = req0_ready;
      acc1 = req1_ready;
      chk1("alt_g0", acc0, (i % 2) == 0);
      chk1("alt_g1", acc1, (i % 2) == 1);
      if (acc0) n0++;
      if (acc1) n1++;
      step();
      if (acc0) begin req0_a = rnd16(); req0_b = rnd16(); req0_sub = 1'($urandom); end
      if (acc1) begin req1_a = rnd16(); req1_b = rnd16(); req1_sub = 1'($urandom); end
    end
    chk32("alt_count0", n0, 4);
    chk32("alt_count1", n1, 4);
    chk32("alt_no_idle", n0 + n1, 8);

    // Reset while port 0 holds a result.
    req1_valid = 1'b0;
    rsp0_ready = 1'b0;
    req0_a = 16'h0010; req0_b = 16'h0001; req0_sub = 1'b0; req0_valid = 1'b1;
    @(negedge clk);
    chk1("mid_req0_ready", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk1("mid_held_valid", rsp0_valid, 1'b1);
    chk16("mid_held_s", rsp0_s, 16'h0011);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rsp0_ready = 1'b1;
    req0_valid = 1'b1;
    req1_a = 16'h0002; req1_b = 16'h0002; req1_sub = 1'b0; req1_valid = 1'b1;
    @(negedge clk);
    chk1("post_rst_rsp0_valid", rsp0_valid, 1'b0);
    chk16("post_rst_rsp0_s", rsp0_s, 16'h0000);
    chk1("post_rst_tie_req0", req0_ready, 1'b1);
    chk1("post_rst_tie_req1", req1_ready, 1'b0);

    // Randomized traffic; requesters hold inputs until accepted.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      step();
      if (acc0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_a = rnd16(); req0_b = rnd16(); req0_sub = 1'($urandom);
      end
      if (acc1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_a = rnd16(); req1_b = rnd16(); req1_sub = 1'($urandom);
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain: consumers always ready, requests stop once accepted.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      step();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
    end
    @(negedge clk);
    chk32("drain_q0_empty", q0.size(), 0);
    chk32("drain_q1_empty", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
